// File: rtl/rr_arbiter_16_pkg.sv
// Shared types and constants for the 16-way round-robin arbiter.
// Imported by the arbiter top and its testbench.
package rr_arbiter_16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/decoder_4to16.sv
// Binary to one-hot decoder with enable.
// Output is all zero when disabled.
module decoder_4to16 (
  input  logic        i_enable,
  input  logic [3:0]  i_binary_in,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_enable) begin
      o_onehot[i_binary_in] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with a hold limit.
// Grant is registered; one-hot output is decoded from the index.
module rr_arbiter_16
  import rr_arbiter_16_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             hold_expired
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   w_gnt_idx_nxt;
  logic               r_gnt_valid;
  logic               w_gnt_valid_nxt;
  logic               r_hold_exp;
  logic               w_hold_exp_nxt;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [CNT_W-1:0]   w_hold_cnt_nxt;
  logic [IDX_W-1:0]   w_winner;
  logic               w_rel_req;
  logic               w_rel_en;
  logic               w_rel_max;

  // Rotate so ptr lands at bit 0, pick lowest set bit, rotate back.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [N_REQ-1:0] f_req,
    input logic [IDX_W-1:0] f_ptr
  );
    logic [2*N_REQ-1:0] f_dbl;
    logic [N_REQ-1:0]   f_rot;
    logic [IDX_W-1:0]   f_off;
    f_dbl = {f_req, f_req} >> f_ptr;
    f_rot = f_dbl[N_REQ-1:0];
    f_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (f_rot[i]) begin
        f_off = IDX_W'(i);
      end
    end
    return f_ptr + f_off;
  endfunction

  assign w_winner  = rr_pick(req, r_ptr);
  assign w_rel_req = ~req[r_gnt_idx];
  assign w_rel_en  = ~enable;
  assign w_rel_max = (r_hold_cnt == CNT_W'(MAX_HOLD));

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_idx_nxt   = r_gnt_idx;
    w_gnt_valid_nxt = r_gnt_valid;
    w_hold_exp_nxt  = 1'b0;
    w_ptr_nxt       = r_ptr;
    w_hold_cnt_nxt  = r_hold_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (enable && (req != '0)) begin
          w_state_nxt     = ST_GRANT;
          w_gnt_idx_nxt   = w_winner;
          w_gnt_valid_nxt = 1'b1;
          w_hold_cnt_nxt  = CNT_W'(1);
        end
      end
      ST_GRANT: begin
        if (w_rel_req || w_rel_en || w_rel_max) begin
          w_state_nxt     = ST_IDLE;
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_gnt_idx + IDX_W'(1);
          // Pulse only when the limit alone revoked the grant.
          w_hold_exp_nxt  = w_rel_max & ~w_rel_req & ~w_rel_en;
        end else begin
          w_hold_cnt_nxt  = r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_hold_exp  <= 1'b0;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_idx   <= w_gnt_idx_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_hold_exp  <= w_hold_exp_nxt;
      r_ptr       <= w_ptr_nxt;
      r_hold_cnt  <= w_hold_cnt_nxt;
    end
  end

  decoder_4to16 u_dec (
    .i_enable    (r_gnt_valid),
    .i_binary_in (r_gnt_idx),
    .o_onehot    (gnt)
  );

  assign gnt_idx      = r_gnt_idx;
  assign gnt_valid    = r_gnt_valid;
  assign hold_expired = r_hold_exp;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Scoreboard testbench for rr_arbiter_16.
// Reference model predicts each cycle; monitor compares on negedge.
module tb_rr_arbiter_16;

  localparam int MH = 8;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        hold_expired;

  rr_arbiter_16 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .req          (req),
    .gnt          (gnt),
    .gnt_idx      (gnt_idx),
    .gnt_valid    (gnt_valid),
    .hold_expired (hold_expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v;
    int idx;
    bit x;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: is a grant active, who holds it, for how long,
  // and where the next scan starts.
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_cnt;
  bit m_exp;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 0;
    m_cnt   = 0;
    m_exp   = 0;
  endtask

  task automatic model_step(input bit en, input logic [15:0] rq);
    bit a, b, c;
    if (!m_valid) begin
      m_exp = 0;
      if (en && rq != 16'h0) begin
        for (int k = 0; k < 16; k++) begin
          if (rq[(m_ptr + k) % 16]) begin
            m_idx = (m_ptr + k) % 16;
            break;
          end
        end
        m_valid = 1;
        m_cnt   = 1;
      end
    end else begin
      a = !rq[m_idx];
      b = !en;
      c = (m_cnt == MH);
      if (a || b || c) begin
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 16;
        m_exp   = c && !a && !b;
      end else begin
        m_cnt++;
        m_exp = 0;
      end
    end
  endtask

  // One clock: drive inputs, predict the state after the edge, queue it.
  task automatic step(input bit en, input logic [15:0] rq);
    exp_t e;
    enable = en;
    req    = rq;
    @(posedge clk);
    model_step(en, rq);
    e.v = m_valid;
    e.idx = m_idx;
    e.x = m_exp;
    q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t  e;
    logic [15:0] eg;
    if (q.size() > 0) begin
      e  = q.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      chk("gnt", gnt, eg);
      chk("gnt_valid", {15'b0, gnt_valid}, {15'b0, e.v});
      chk("gnt_idx", {12'b0, gnt_idx}, 16'(e.idx));
      chk("hold_expired", {15'b0, hold_expired}, {15'b0, e.x});
      chk("gnt_onehot0", {15'b0, $onehot0(gnt)}, 16'h1);
    end
  end

  logic [15:0] pend;
  int          keep[16];
  int          waitc[16];
  int          maxw;

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = 16'h0;
    model_reset();
    #1;
    chk("rst_gnt", gnt, 16'h0);
    chk("rst_valid", {15'b0, gnt_valid}, 16'h0);
    chk("rst_idx", {12'b0, gnt_idx}, 16'h0);
    chk("rst_hexp", {15'b0, hold_expired}, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Rotation between two held requesters under the hold limit.
    for (int i = 0; i < 19; i++) begin
      step(1'b1, 16'h0011);
      if (i == 8) chk("rot_pulse", {15'b0, hold_expired}, 16'h1);
      if (i == 9) chk("rot_idx4", {12'b0, gnt_idx}, 16'h4);
    end
    chk("rot_back0", {12'b0, gnt_idx}, 16'h0);
    step(1'b1, 16'h0000);
    step(1'b1, 16'h0000);

    // Early release by requester 15, pointer wraps to 0.
    for (int i = 0; i < 3; i++) step(1'b1, 16'h8000);
    chk("early_gnt", gnt, 16'h8000);
    step(1'b1, 16'h0000);
    chk("early_nopulse", {15'b0, hold_expired}, 16'h0);
    step(1'b1, 16'h0003);
    chk("early_wrap", {12'b0, gnt_idx}, 16'h0);
    step(1'b1, 16'h0000);

    // Enable gating.
    step(1'b1, 16'h0020);
    step(1'b1, 16'h0020);
    step(1'b0, 16'h0020);
    chk("en_drop", {15'b0, gnt_valid}, 16'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 16'hFFFF);
    chk("en_block", {15'b0, gnt_valid}, 16'h0);

    // Wrap scan from pointer 14.
    step(1'b1, 16'h2000);
    step(1'b1, 16'h0000);
    step(1'b1, 16'h0402);
    chk("wrap_idx1", {12'b0, gnt_idx}, 16'h1);
    step(1'b1, 16'h0400);
    step(1'b1, 16'h0400);
    chk("wrap_idx10", {12'b0, gnt_idx}, 16'ha);
    step(1'b1, 16'h0000);

    // Asynchronous reset in the middle of a grant.
    step(1'b1, 16'h0010);
    step(1'b1, 16'h0010);
    req = 16'hFFFF;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_gnt", gnt, 16'h0);
    chk("mrst_valid", {15'b0, gnt_valid}, 16'h0);
    chk("mrst_idx", {12'b0, gnt_idx}, 16'h0);
    chk("mrst_hexp", {15'b0, hold_expired}, 16'h0);
    model_reset();
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 16'hFFFF);
    chk("mrst_first", {12'b0, gnt_idx}, 16'h0);
    step(1'b1, 16'h0000);

    // Fully random inputs.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 9) != 0, 16'($urandom & $urandom));
    end
    step(1'b1, 16'h0000);
    step(1'b1, 16'h0000);

    // Requesters hold until served; track the longest wait.
    pend = 16'h0;
    maxw = 0;
    for (int i = 0; i < 16; i++) begin
      keep[i]  = 0;
      waitc[i] = 0;
    end
    for (int n = 0; n < 5000; n++) begin
      for (int i = 0; i < 16; i++) begin
        if (!pend[i] && $urandom_range(0, 7) == 0) begin
          pend[i] = 1'b1;
          keep[i] = $urandom_range(1, 12);
        end
      end
      step(1'b1, pend);
      for (int i = 0; i < 16; i++) begin
        if (m_valid && m_idx == i) begin
          waitc[i] = 0;
          keep[i]--;
          if (keep[i] <= 0) pend[i] = 1'b0;
        end else if (pend[i]) begin
          waitc[i]++;
          if (waitc[i] > maxw) maxw = waitc[i];
        end
      end
    end
    // Worst case: own release gap, then 15 others each grant plus gap.
    checks++;
    if (maxw > 15 * (MH + 1) + 1) begin
      errors++;
      $display("FAIL starvation: max wait %0d limit %0d",
               maxw, 15 * (MH + 1) + 1);
    end

    @(negedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
